// File: rtl/alu_issue_controller.sv
// rtl/alu_issue_controller.sv - command FIFO and issue FSM driving a combinational 6-bit ALU.
// Results are captured after one settle cycle and returned on a valid/ready response port.
module alu_issue_controller #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_instr,
  input  logic [5:0]        cmd_a,
  input  logic [5:0]        cmd_b,
  output logic [ADDR_W:0]   cmd_count,
  output logic [3:0]        alu_instr,
  output logic [5:0]        alu_a,
  output logic [5:0]        alu_b,
  input  logic [11:0]       alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [11:0]       rsp_result,
  output logic              rsp_err,
  output logic [3:0]        rsp_instr
);

  localparam logic [3:0] OP_MOD = 4'b1010;
  localparam logic [3:0] OP_DIV = 4'b1100;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t state, state_next;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push, pop, err;

  assign cmd_ready = (count != FULL);
  assign cmd_count = count;
  assign push      = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RESP);

  // Error uses only the registered opcode and B, never the ALU output.
  assign err = (alu_instr inside {[4'd3:4'd7]}) ||
               (((alu_instr == OP_DIV) || (alu_instr == OP_MOD)) && (alu_b == 6'd0));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_instr, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (count != '0) begin
            pop        = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_instr  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      rsp_instr  <= '0;
    end else begin
      if (pop) {alu_instr, alu_a, alu_b} <= mem[rd_ptr];
      if (state == DRIVE) begin
        rsp_result <= err ? 12'd0 : alu_result;
        rsp_err    <= err;
        rsp_instr  <= alu_instr;
      end
    end
  end

endmodule
